// File: rtl/fifo_rr_ctrl_if.sv
// fifo_rr_ctrl_if: producer, consumer, flush and FIFO-port signals.
// master = environment (producers, consumer, FIFO); slave = controller.
interface fifo_rr_ctrl_if #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int CW   = 5
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic               rd_req;
  logic               rd_valid;
  logic [DW-1:0]      rd_data;
  logic               flush;
  logic               flush_done;
  logic               busy;
  logic [CW-1:0]      count;
  logic               fifo_write;
  logic [DW-1:0]      fifo_din;
  logic               fifo_read;
  logic [DW-1:0]      fifo_dout;

  modport master (
    output req, req_data, rd_req, flush, fifo_dout,
    input  ack, rd_valid, rd_data, flush_done, busy,
    input  count, fifo_write, fifo_din, fifo_read
  );

  modport slave (
    input  req, req_data, rd_req, flush, fifo_dout,
    output ack, rd_valid, rd_data, flush_done, busy,
    output count, fifo_write, fifo_din, fifo_read
  );
endinterface

// File: rtl/fifo_rr_ctrl.sv
// fifo_rr_ctrl: round-robin write mux, read sequencer and flush for a FIFO.
// Ports: clk, reset (sync, active-high), bus (slave view of fifo_rr_ctrl_if).
module fifo_rr_ctrl #(
  parameter int NREQ  = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input logic           clk,
  input logic           reset,
  fifo_rr_ctrl_if.slave bus
);
  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [RW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   din_q, din_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic            pipe_q, pipe_d;
  logic            done_q, done_d;
  logic            vld_q;
  logic            busy_q;

  logic [NREQ-1:0] elig;
  logic [RW-1:0]   win, idx;
  logic            found;
  logic            run, rd_go, room, wr_go;
  logic [DW-1:0]   slot [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign slot[g] = bus.req_data[g*DW +: DW];
  end

  // flush wins over any grant or read on its edge
  assign run   = (state_q == RUN) && !bus.flush;
  assign rd_go = run && bus.rd_req && (count_q != '0);
  // a read on the same edge frees a slot for the write
  assign room  = (count_q - CW'(rd_go)) < CW'(DEPTH);
  // last cycle's winner may still hold req during its ack
  assign elig  = bus.req & ~mask_q;
  assign wr_go = run && found && room;

  always_comb begin
    found = 1'b0;
    win   = rr_q;
    idx   = rr_q;
    for (int i = 0; i < NREQ; i++) begin
      idx = RW'((int'(rr_q) + i) % NREQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    mask_d  = '0;
    rr_d    = rr_q;
    din_d   = din_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    pipe_d  = 1'b0;
    done_d  = 1'b0;
    count_d = count_q;
    unique case (1'b1)
      (state_q == FLUSH): begin
        rd_d    = (count_q != '0);
        count_d = count_q - CW'(rd_d);
        if (count_d == '0) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (bus.flush) begin
          state_d = FLUSH;
        end else begin
          rd_d   = rd_go;
          pipe_d = rd_go;
          if (wr_go) begin
            wr_d   = 1'b1;
            ack_d  = NREQ'(1) << win;
            mask_d = NREQ'(1) << win;
            din_d  = slot[win];
            rr_d   = (win == RW'(NREQ-1)) ? '0 : win + 1'b1;
          end
          count_d = count_q + CW'(wr_go) - CW'(rd_go);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ack_q   <= '0;
      mask_q  <= '0;
      rr_q    <= '0;
      count_q <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      pipe_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      mask_q  <= mask_d;
      rr_q    <= rr_d;
      count_q <= count_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pipe_q  <= pipe_d;
      done_q  <= done_d;
      // dout registers one edge after the read strobe
      vld_q   <= pipe_q;
      busy_q  <= (state_d == FLUSH);
    end
  end

  assign bus.ack        = ack_q;
  assign bus.fifo_write = wr_q;
  assign bus.fifo_din   = din_q;
  assign bus.fifo_read  = rd_q;
  assign bus.rd_valid   = vld_q;
  assign bus.rd_data    = bus.fifo_dout;
  assign bus.flush_done = done_q;
  assign bus.busy       = busy_q;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// tb_fifo_rr_ctrl: directed and random checks of fifo_rr_ctrl.
// Holds a FIFO stand-in and a queue-based reference of the controller.
module tb_fifo_rr_ctrl;
  localparam int NREQ  = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int WD    = NREQ * DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_rr_ctrl_if #(.NREQ(NREQ), .DW(DW), .CW(CW)) bus ();

  fifo_rr_ctrl #(
    .NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // FIFO stand-in: registered dout, errors on under/overflow
  logic [DW-1:0] fq [$];
  logic [DW-1:0] dout_q;
  int            fifo_err = 0;
  assign bus.fifo_dout = dout_q;

  always @(posedge clk) begin
    if (reset) begin
      fq.delete();
      dout_q <= '0;
    end else begin
      if (bus.fifo_read) begin
        if (fq.size() == 0) fifo_err <= fifo_err + 1;
        else dout_q <= fq.pop_front();
      end
      if (bus.fifo_write) begin
        if (fq.size() >= DEPTH) fifo_err <= fifo_err + 1;
        else fq.push_back(bus.fifo_din);
      end
    end
  end

  // reference state
  int            m_cnt, m_ptr, m_last;
  bit            m_fl, m_pend;
  logic [DW-1:0] m_pdata;
  logic [DW-1:0] mq [$];

  logic [NREQ-1:0] e_ack;
  logic            e_wr, e_rd, e_val, e_done, e_busy;
  logic [DW-1:0]   e_din, e_rdata;
  logic [CW-1:0]   e_cnt;

  logic [17:0] obs, expv;
  assign obs = {bus.ack, bus.fifo_write, bus.fifo_din,
                bus.fifo_read, bus.rd_valid, bus.flush_done,
                bus.busy, bus.count};
  assign expv = {e_ack, e_wr, e_din, e_rd, e_val,
                 e_done, e_busy, e_cnt};

  // one clock: advance the reference from the inputs seen at the edge
  task automatic step();
    int win, i;
    bit rd;
    logic [NREQ-1:0] rq;
    @(posedge clk);
    rq = bus.req;
    if (reset) begin
      m_cnt = 0; m_ptr = 0; m_last = -1;
      m_fl = 0; m_pend = 0;
      mq.delete();
      e_ack = '0; e_wr = 0; e_rd = 0; e_val = 0;
      e_done = 0; e_busy = 0; e_din = '0; e_cnt = '0;
    end else begin
      e_val = m_pend;
      e_rdata = m_pdata;
      m_pend = 0;
      e_ack = '0; e_wr = 0; e_rd = 0; e_done = 0;
      if (!m_fl && bus.flush) begin
        m_fl = 1;
        m_last = -1;
      end else if (!m_fl) begin
        rd = bus.rd_req && (m_cnt > 0);
        if (rd) begin
          m_pdata = mq.pop_front();
          m_pend = 1;
        end
        win = -1;
        if (m_cnt - int'(rd) < DEPTH) begin
          for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (win < 0 && bit'(rq >> i) && i != m_last) win = i;
          end
        end
        m_last = win;
        if (win >= 0) begin
          e_wr = 1;
          e_ack = NREQ'(1) << win;
          e_din = DW'(bus.req_data >> (win * DW));
          mq.push_back(e_din);
          m_ptr = (win + 1) % NREQ;
        end
        e_rd = rd;
        m_cnt = m_cnt + int'(win >= 0) - int'(rd);
      end else begin
        if (m_cnt > 0) begin
          e_rd = 1;
          m_cnt = m_cnt - 1;
          void'(mq.pop_front());
        end
        if (m_cnt == 0) begin
          m_fl = 0;
          e_done = 1;
        end
      end
      e_busy = m_fl;
      e_cnt = CW'(m_cnt);
    end
    #1;
  endtask

  task automatic idle();
    bus.req = '0;
    bus.req_data = '0;
    bus.rd_req = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = '1;
    bus.req_data = WD'($urandom);
    bus.rd_req = 1'b1;
    bus.flush = 1'b1;
    step();
    step();
    n_chk++;
    if (obs !== 18'h0) begin
      $display("FAIL reset_state: got %h want 0", obs);
      n_fail++;
    end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_rotate();
    do_reset();
    bus.req = 4'b1111;
    bus.req_data = 16'h4321;
    for (int k = 0; k < 12; k++) begin
      step();
      n_chk++;
      if (obs !== expv) begin
        $display("FAIL rotate_model: got %h want %h", obs, expv);
        n_fail++;
      end
      n_chk++;
      if ({bus.ack, bus.fifo_din} !==
          {NREQ'(1) << (k % 4), DW'(k % 4 + 1)}) begin
        $display("FAIL rotate_order k=%0d: ack %b din %h",
                 k, bus.ack, bus.fifo_din);
        n_fail++;
      end
    end
    idle();
  endtask

  task automatic test_mask();
    do_reset();
    bus.req = 4'b0100;
    bus.req_data = 16'h0A00;
    for (int k = 0; k < 8; k++) begin
      step();
      n_chk++;
      if (obs !== expv) begin
        $display("FAIL mask_model: got %h want %h", obs, expv);
        n_fail++;
      end
      n_chk++;
      if ({bus.ack, bus.count} !==
          {(k % 2 == 0) ? 4'b0100 : 4'b0000, CW'(k / 2 + 1)}) begin
        $display("FAIL mask_alt k=%0d: ack %b count %0d",
                 k, bus.ack, bus.count);
        n_fail++;
      end
    end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    bus.req = 4'b1111;
    bus.req_data = WD'($urandom);
    for (int k = 0; k < 20; k++) begin
      step();
      n_chk++;
      if (obs !== expv) begin
        $display("FAIL full_model: got %h want %h", obs, expv);
        n_fail++;
      end
    end
    n_chk++;
    if ({bus.count, bus.fifo_write, bus.ack} !== {CW'(16), 1'b0, 4'b0}) begin
      $display("FAIL full_stop: count %0d wr %b ack %b",
               bus.count, bus.fifo_write, bus.ack);
      n_fail++;
    end
    bus.rd_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.req_data = WD'($urandom);
      step();
      n_chk++;
      if (obs !== expv) begin
        $display("FAIL full_rw_model: got %h want %h", obs, expv);
        n_fail++;
      end
      n_chk++;
      if ({bus.count, bus.fifo_write, bus.rd_valid} !==
          {CW'(16), 1'b1, k >= 1}) begin
        $display("FAIL full_rw k=%0d: count %0d wr %b vld %b",
                 k, bus.count, bus.fifo_write, bus.rd_valid);
        n_fail++;
      end
      if (e_val) begin
        n_chk++;
        if (bus.rd_data !== e_rdata) begin
          $display("FAIL full_rdata: got %h want %h",
                   bus.rd_data, e_rdata);
          n_fail++;
        end
      end
    end
    idle();
  endtask

  task automatic test_empty_read();
    do_reset();
    bus.rd_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++;
      if ({bus.fifo_read, bus.rd_valid} !== 2'b00) begin
        $display("FAIL empty_read: rd %b vld %b",
                 bus.fifo_read, bus.rd_valid);
        n_fail++;
      end
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    bus.req = 4'b1111;
    bus.req_data = 16'h4321;
    for (int k = 0; k < 5; k++) step();
    bus.req = 4'b0011;
    bus.flush = 1'b1;
    step();
    n_chk++;
    if ({bus.busy, bus.count, bus.ack} !== {1'b1, CW'(5), 4'b0}) begin
      $display("FAIL flush_entry: busy %b count %0d ack %b",
               bus.busy, bus.count, bus.ack);
      n_fail++;
    end
    bus.flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++;
      if (obs !== expv) begin
        $display("FAIL flush_model: got %h want %h", obs, expv);
        n_fail++;
      end
      n_chk++;
      if ({bus.fifo_read, bus.rd_valid, bus.ack, bus.flush_done,
           bus.busy, bus.count} !==
          {1'b1, 1'b0, 4'b0, k == 4, k != 4, CW'(4 - k)}) begin
        $display("FAIL flush_drain k=%0d: got %h", k, obs);
        n_fail++;
      end
    end
    step();
    n_chk++;
    if ({bus.ack, bus.busy} !== {4'b0010, 1'b0}) begin
      $display("FAIL flush_resume: ack %b busy %b", bus.ack, bus.busy);
      n_fail++;
    end
    idle();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) step();
    bus.req = '0;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int k = 0; k < 5; k++) step();
    n_chk++;
    if ({bus.busy, bus.count} !== {1'b1, CW'(3)}) begin
      $display("FAIL midflush_pre: busy %b count %0d",
               bus.busy, bus.count);
      n_fail++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_chk++;
    if (obs !== 18'h0) begin
      $display("FAIL midflush_reset: got %h want 0", obs);
      n_fail++;
    end
    step();
    n_chk++;
    if (obs !== expv) begin
      $display("FAIL midflush_after: got %h want %h", obs, expv);
      n_fail++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      bus.req = NREQ'($urandom);
      bus.req_data = WD'($urandom);
      bus.rd_req = ($urandom_range(0, 2) != 0);
      bus.flush = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
      n_chk++;
      if (obs !== expv) begin
        $display("FAIL random_model k=%0d: got %h want %h",
                 k, obs, expv);
        n_fail++;
      end
      if (e_val) begin
        n_chk++;
        if (bus.rd_data !== e_rdata) begin
          $display("FAIL random_rdata k=%0d: got %h want %h",
                   k, bus.rd_data, e_rdata);
          n_fail++;
        end
      end
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_rotate();
    test_mask();
    test_full();
    test_empty_read();
    test_flush();
    test_reset_mid_flush();
    test_random();
    n_chk++;
    if (fifo_err !== 0) begin
      $display("FAIL fifo_bounds: got %0d errors want 0", fifo_err);
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
